// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - dice_pkg: die-size limits, 7-segment pattern table and the BCD digit type.
package dice_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DICE = 7;

    // Wrap point of each die as two BCD digits; 100 is stored as 00
    localparam logic [7:0] DIE_LIMITS [0:NUM_DICE-1] = '{
        8'h04, 8'h06, 8'h08, 8'h10, 8'h12, 8'h20, 8'h00
    };

    localparam logic [6:0] SEG_PATTERNS [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_of(bcd_t d);
        return (d < 4'd10) ? SEG_PATTERNS[d] : 7'h00;
    endfunction

endpackage

// File: rtl/dice_debounce.sv
// rtl/dice_debounce.sv - dice_debounce: 2-flop button/polarity synchronizer and stable-count debouncer.
module dice_debounce
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] buttons,
    input  logic       polarity,
    output logic [6:0] raw,
    output logic       pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [CW-1:0] stable_cnt;
    logic          any_raw;

    // Polarity strap is synchronized alongside the buttons so both flip together
    assign raw     = sync2[6:0] ^ {7{~sync2[7]}};
    assign any_raw = |raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            stable_cnt <= '0;
            pressed    <= 1'b0;
        end else begin
            sync1 <= {polarity, buttons};
            sync2 <= sync1;
            if (any_raw != pressed) begin
                if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    pressed    <= any_raw;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sanojn_ttrpg_dice.sv
// rtl/sanojn_ttrpg_dice.sv - dice roller top: selection, BCD counter, digit mux, polarity straps.
// Optional DICE_BLANK_ZERO_EN blanks a leading-zero tens digit.
module sanojn_ttrpg_dice
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int MUX_CYCLES      = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int MW = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;

    logic [6:0]    raw;
    logic          pressed;
    logic          pressed_d;
    logic          valid;
    logic          sel;
    logic [MW-1:0] mux_cnt;
    bcd_t          digit1;
    bcd_t          digit10;
    bcd_t          next1;
    bcd_t          next10;
    logic [7:0]    die;
    logic [7:0]    die_sel;
    logic          show;
    logic          tens_blank;
    logic          ones_on;
    logic          tens_on;
    logic [6:0]    seg;
    logic          unused_ok;

    assign unused_ok = &{1'b0, ena, ui_in[7], uio_in[4:0]};

    dice_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .buttons (ui_in[6:0]),
        .polarity(uio_in[5]),
        .raw     (raw),
        .pressed (pressed)
    );

    always_comb begin
        die_sel = DIE_LIMITS[0];
        for (int i = NUM_DICE - 1; i >= 0; i--) begin
            if (raw[i]) die_sel = DIE_LIMITS[i];
        end
    end

    always_comb begin
        next1  = digit1 + 4'd1;
        next10 = digit10;
        if ({digit10, digit1} == die) begin
            next1  = 4'd1;
            next10 = 4'd0;
        end else if (digit1 == 4'd9) begin
            next1  = 4'd0;
            next10 = (digit10 == 4'd9) ? 4'd0 : digit10 + 4'd1;
        end
    end

    // The die tracks the lowest pressed button until the debounced press lands, then freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_d <= 1'b0;
            valid     <= 1'b0;
            digit1    <= '0;
            digit10   <= '0;
            die       <= DIE_LIMITS[0];
        end else begin
            pressed_d <= pressed;
            if (!pressed && (|raw)) die <= die_sel;
            if (pressed && !pressed_d) begin
                digit1  <= 4'd1;
                digit10 <= 4'd0;
                valid   <= 1'b0;
            end else if (pressed) begin
                digit1  <= next1;
                digit10 <= next10;
            end else if (pressed_d) begin
                valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt <= '0;
            sel     <= 1'b0;
        end else if (mux_cnt == MW'(MUX_CYCLES - 1)) begin
            mux_cnt <= '0;
            sel     <= ~sel;
        end else begin
            mux_cnt <= mux_cnt + 1'b1;
        end
    end

`ifdef DICE_BLANK_ZERO_EN
    assign tens_blank = (digit10 == 4'd0) && !((die == 8'h00) && (digit1 == 4'd0));
`else
    assign tens_blank = 1'b0;
`endif

    assign show    = valid && !pressed;
    assign ones_on = show && !sel;
    assign tens_on = show && sel && !tens_blank;
    assign seg     = ones_on ? seg_of(digit1) : (tens_on ? seg_of(digit10) : 7'h00);

    assign uo_out  = {1'b0, seg} ^ {8{~uio_in[6]}};
    assign uio_out = {6'b0,
                      tens_on ? uio_in[7] : ~uio_in[7],
                      ones_on ? uio_in[7] : ~uio_in[7]};
    assign uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_sanojn_ttrpg_dice.sv
// tb/tb_sanojn_ttrpg_dice.sv - directed-vector bench for sanojn_ttrpg_dice.
module tb_sanojn_ttrpg_dice;

    localparam int DEB = 4;
    localparam int MUX = 8;
`ifdef DICE_BLANK_ZERO_EN
    localparam bit BZ = 1'b1;
`else
    localparam bit BZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'hE0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors = 0;
    int miscompares = 0;

    sanojn_ttrpg_dice #(
        .DEBOUNCE_CYCLES(DEB),
        .MUX_CYCLES     (MUX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] press_val(input logic [6:0] mask);
        return uio_in[5] ? {1'b0, mask} : {1'b0, ~mask};
    endfunction

    task automatic check_blank(input string tag);
        check({tag, "_seg"}, 16'(uo_out), 16'({8{~uio_in[6]}}));
        check({tag, "_com"}, 16'(uio_out[1:0]), 16'({2{~uio_in[7]}}));
    endtask

    task automatic roll(input logic [6:0] mask, input int h);
        ui_in = press_val(mask);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            if (i == DEB + 3) check_blank("held");
        end
        ui_in = press_val(7'h00);
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic expect_display(input string tag, input logic [7:0] e_ones,
                                  input logic [7:0] e_tens, input bit tens_shown);
        logic [7:0] ones;
        logic [7:0] tens;
        logic [7:0] inv;
        int         ones_cnt;
        int         tens_cnt;
        int         both_cnt;
        ones = 8'h00;
        tens = 8'h00;
        ones_cnt = 0;
        tens_cnt = 0;
        both_cnt = 0;
        repeat (4 * MUX) begin
            @(negedge clk);
            if (uio_out[0] == uio_in[7]) begin
                ones = uo_out;
                ones_cnt++;
            end
            if (uio_out[1] == uio_in[7]) begin
                tens = uo_out;
                tens_cnt++;
            end
            if (uio_out[0] == uio_in[7] && uio_out[1] == uio_in[7]) both_cnt++;
        end
        inv = {8{~uio_in[6]}};
        check({tag, "_ones"}, 16'(ones), 16'(e_ones ^ inv));
        check({tag, "_ones_cycles"}, 16'(ones_cnt), 16'(2 * MUX));
        check({tag, "_both_active"}, 16'(both_cnt), 16'd0);
        if (tens_shown) begin
            check({tag, "_tens"}, 16'(tens), 16'(e_tens ^ inv));
            check({tag, "_tens_cycles"}, 16'(tens_cnt), 16'(2 * MUX));
        end else begin
            check({tag, "_tens_cycles"}, 16'(tens_cnt), 16'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", 16'(uo_out), 16'h0000);
        check("rst_com", 16'(uio_out), 16'h0000);
        check("rst_oe", 16'(uio_oe), 16'h0003);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_blank("idle");

        roll(7'h02, 9);
        expect_display("d6_h9", 8'h4F, 8'h3F, !BZ);

        uio_in = 8'h00;
        ui_in  = 8'h7F;
        repeat (4) @(negedge clk);
        check("inv_idle_oe", 16'(uio_oe), 16'h0003);

        roll(7'h40, 100);
        expect_display("d100_h100", 8'h3F, 8'h3F, 1'b1);

        roll(7'h08, 10);
        expect_display("d10_h10", 8'h3F, 8'h06, 1'b1);

        roll(7'h21, 5);
        expect_display("d4_d20_h5", 8'h06, 8'h3F, !BZ);

        ui_in = press_val(7'h04);
        repeat (2) @(negedge clk);
        ui_in = press_val(7'h00);
        repeat (DEB + 4) @(negedge clk);
        expect_display("glitch_d8", 8'h06, 8'h3F, !BZ);

        roll(7'h04, 7);
        expect_display("d8_h7", 8'h07, 8'h3F, !BZ);

        roll(7'h10, 12);
        expect_display("d12_h12", 8'h5B, 8'h06, 1'b1);

        roll(7'h20, 25);
        expect_display("d20_h25", 8'h6D, 8'h3F, !BZ);

        ui_in = press_val(7'h02);
        repeat (DEB + 5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_blank("rst_mid_roll");
        ui_in = press_val(7'h00);
        rst_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        check_blank("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
